// File: rtl/hazard_ctrl_pkg.sv
// Shared pipeline definitions: register-address width, NOP encoding and
// the hazard controller state type.
package hazard_ctrl_pkg;

  localparam int          REG_ADDR_W = 5;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  typedef enum logic [1:0] {
    RUN          = 2'd0,
    FREEZE       = 2'd1,
    FREEZE_REDIR = 2'd2
  } hz_state_e;

endpackage

// File: rtl/hazard_ctrl_perf_counter.sv
// Event counter: increments by one per enabled cycle, wrapping unless the
// saturating variant is selected.
module perf_counter #(
  parameter int CNT_W    = 32,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_reg;
  logic             hold;

  assign hold = SATURATE && (&cnt_reg);
  assign cnt  = cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (inc && !hold) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: memory-busy freeze, taken-branch flush
// (remembered across a freeze) and single-bubble load-use stall.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] ID_rs1_addr,
  input  logic [REG_ADDR_W-1:0] ID_rs2_addr,
  input  logic [REG_ADDR_W-1:0] EX_rd_addr,
  input  logic                  EX_MemRead,
  input  logic                  EX_branch_taken,
  input  logic                  IM_stall,
  input  logic                  DM_stall,
  output logic                  PC_write,
  output logic                  IF_ID_write,
  output logic                  ID_EX_write,
  output logic                  EX_MEM_write,
  output logic                  MEM_WB_write,
  output logic                  IF_ID_flush,
  output logic                  ID_EX_flush,
  output logic                  PC_redirect,
  output logic [CNT_W-1:0]      lu_stall_cnt,
  output logic [CNT_W-1:0]      flush_cnt,
  output logic [CNT_W-1:0]      freeze_cnt
);

  hz_state_e state_reg, state_next;

  logic mem_busy;
  logic load_use;
  logic lu_applied;
  logic [2:0] cnt_inc;
  logic [CNT_W-1:0] cnt_val [3];

  assign mem_busy = IM_stall | DM_stall;
  assign load_use = EX_MemRead && (EX_rd_addr != '0) &&
                    ((EX_rd_addr == ID_rs1_addr) || (EX_rd_addr == ID_rs2_addr));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    PC_write     = 1'b1;
    IF_ID_write  = 1'b1;
    ID_EX_write  = 1'b1;
    EX_MEM_write = 1'b1;
    MEM_WB_write = 1'b1;
    IF_ID_flush  = 1'b0;
    ID_EX_flush  = 1'b0;
    PC_redirect  = 1'b0;
    lu_applied   = 1'b0;

    if (!rst) begin
      state_next = RUN;
    end else if (mem_busy) begin
      PC_write     = 1'b0;
      IF_ID_write  = 1'b0;
      ID_EX_write  = 1'b0;
      EX_MEM_write = 1'b0;
      MEM_WB_write = 1'b0;
      // A branch seen during a freeze must be replayed once the freeze lifts.
      if (EX_branch_taken || state_reg == FREEZE_REDIR) begin
        state_next = FREEZE_REDIR;
      end else begin
        state_next = FREEZE;
      end
    end else begin
      state_next = RUN;
      if (EX_branch_taken || state_reg == FREEZE_REDIR) begin
        PC_redirect = 1'b1;
        IF_ID_flush = 1'b1;
        ID_EX_flush = 1'b1;
      end else if (load_use) begin
        PC_write    = 1'b0;
        IF_ID_write = 1'b0;
        ID_EX_flush = 1'b1;
        lu_applied  = 1'b1;
      end
    end
  end

  assign cnt_inc = {mem_busy, PC_redirect, lu_applied};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
      perf_counter #(
        .CNT_W   (CNT_W),
        .SATURATE(1'b0)
      ) u_cnt (
        .clk(clk),
        .rst(rst),
        .inc(cnt_inc[gi]),
        .cnt(cnt_val[gi])
      );
    end
  endgenerate

  assign lu_stall_cnt = cnt_val[0];
  assign flush_cnt    = cnt_val[1];
  assign freeze_cnt   = cnt_val[2];

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: a driver pushes model predictions, a
// monitor at mid-cycle pops and compares them against the DUT.
module tb_hazard_ctrl;

  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic [4:0] rs1 = '0, rs2 = '0, rd = '0;
  logic mem_read = 1'b0, br = 1'b0, im_stall = 1'b0, dm_stall = 1'b0;
  logic pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, pc_r;
  logic [CW-1:0] lu_cnt, fl_cnt, fz_cnt;

  always #5 clk = ~clk;

  hazard_ctrl #(.CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .ID_rs1_addr(rs1), .ID_rs2_addr(rs2), .EX_rd_addr(rd),
    .EX_MemRead(mem_read), .EX_branch_taken(br),
    .IM_stall(im_stall), .DM_stall(dm_stall),
    .PC_write(pc_w), .IF_ID_write(ifid_w), .ID_EX_write(idex_w),
    .EX_MEM_write(exmem_w), .MEM_WB_write(memwb_w),
    .IF_ID_flush(ifid_f), .ID_EX_flush(idex_f), .PC_redirect(pc_r),
    .lu_stall_cnt(lu_cnt), .flush_cnt(fl_cnt), .freeze_cnt(fz_cnt)
  );

  // ctl = {PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write,
  //        IF_ID_flush, ID_EX_flush, PC_redirect}
  typedef struct packed {
    logic [7:0]    ctl;
    logic [CW-1:0] lu;
    logic [CW-1:0] fl;
    logic [CW-1:0] fz;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;

  // Reference model state: a branch owed after the freeze, plus event tallies.
  bit pending_redirect = 0;
  int n_lu = 0, n_fl = 0, n_fz = 0;

  task automatic model_and_push(input bit in_reset);
    exp_t e;
    bit busy, hit, redir;
    busy  = im_stall | dm_stall;
    hit   = mem_read && rd != 0 && (rd == rs1 || rd == rs2);
    redir = br || pending_redirect;
    e.lu = CW'(n_lu % (1 << CW));
    e.fl = CW'(n_fl % (1 << CW));
    e.fz = CW'(n_fz % (1 << CW));
    if (in_reset) begin
      e = '0;
      e.ctl = 8'b11111_000;
      pending_redirect = 0;
      n_lu = 0; n_fl = 0; n_fz = 0;
    end else if (busy) begin
      e.ctl = 8'b00000_000;
      n_fz++;
      if (br) pending_redirect = 1;
    end else if (redir) begin
      e.ctl = 8'b11111_111;
      n_fl++;
      pending_redirect = 0;
    end else if (hit) begin
      e.ctl = 8'b00111_010;
      n_lu++;
    end else begin
      e.ctl = 8'b11111_000;
    end
    exp_q.push_back(e);
  endtask

  task automatic drive(input bit ims, input bit dms, input bit b, input bit mr,
                       input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2);
    @(posedge clk); #1;
    rst = 1'b1;
    im_stall = ims; dm_stall = dms; br = b; mem_read = mr;
    rd = d; rs1 = s1; rs2 = s2;
    model_and_push(1'b0);
  endtask

  task automatic reset_cycle(input bit dms, input bit b);
    @(posedge clk); #1;
    rst = 1'b0;
    dm_stall = dms; br = b; im_stall = 1'b0;
    mem_read = 1'b1; rd = 5'd3; rs1 = 5'd3; rs2 = 5'd0;
    model_and_push(1'b1);
  endtask

  task automatic cmp(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL txn %0d %s: got %0h expected %0h", txn, name, act, req);
    end
  endtask

  // Monitor: compares at mid-cycle, after inputs settle and clear of edges.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      cmp("ctl", int'({pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, pc_r}), int'(e.ctl));
      cmp("lu_stall_cnt", int'(lu_cnt), int'(e.lu));
      cmp("flush_cnt", int'(fl_cnt), int'(e.fl));
      cmp("freeze_cnt", int'(fz_cnt), int'(e.fz));
      $display("txn %0d ctl=%b lu=%0d fl=%0d fz=%0d", txn,
               {pc_w, ifid_w, idex_w, exmem_w, memwb_w, ifid_f, idex_f, pc_r},
               lu_cnt, fl_cnt, fz_cnt);
      txn++;
    end
  end

  initial begin
    // Reset with a freeze request present: outputs must stay at defaults.
    reset_cycle(1'b1, 1'b1);
    reset_cycle(1'b0, 1'b0);
    // Load-use on rs2, then idle to see lu_stall_cnt=1.
    drive(0, 0, 0, 1, 5'd5, 5'd1, 5'd5);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // rd=0 never stalls.
    drive(0, 0, 0, 1, 5'd0, 5'd0, 5'd2);
    // Three-cycle data freeze with a branch in the second cycle.
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 0, 0, 1, 5'd7, 5'd7, 5'd0);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Branch together with a load-use match: flush wins.
    drive(0, 0, 1, 1, 5'd9, 5'd9, 5'd9);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Plain freeze releasing into a load-use stall.
    drive(1, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 0, 0, 1, 5'd4, 5'd4, 5'd1);
    // Reset while a redirect is stored: it must be dropped.
    drive(0, 1, 1, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 1, 0, 0, 5'd0, 5'd0, 5'd0);
    reset_cycle(1'b1, 1'b0);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // 17 freeze cycles wrap the 4-bit counter to 1.
    for (int i = 0; i < 17; i++) drive(i[0], 1, 0, 0, 5'd0, 5'd0, 5'd0);
    drive(0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    // Randomized traffic on a small register range to provoke matches.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 99) == 0) reset_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      else drive($urandom_range(0, 7) == 0, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 5'($urandom_range(0, 3)));
    end
    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d pending, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter CNT_W, default 32, meaning the width of the performance counters.
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port ID_rs1_addr, input, 5, rs1 of the instruction in ID.
REQ-005 SHALL have port ID_rs2_addr, input, 5, rs2 of the instruction in ID.
REQ-006 SHALL have port EX_rd_addr, input, 5, rd of the instruction in EX.
REQ-007 SHALL have port EX_MemRead, input, 1, the EX instruction is a load.
REQ-008 SHALL have port EX_branch_taken, input, 1, one-cycle pulse per taken branch/jump resolved in EX, issued even while frozen.
REQ-009 SHALL have port IM_stall, input, 1, instruction memory busy.
REQ-010 SHALL have port DM_stall, input, 1, data memory busy.
REQ-011 SHALL have ports PC_write, IF_ID_write, ID_EX_write, EX_MEM_write, MEM_WB_write, output, 1 each, stage-register enables.
REQ-012 SHALL have ports IF_ID_flush, ID_EX_flush, output, 1 each, which insert a NOP into that register on the next edge.
REQ-013 SHALL have port PC_redirect, output, 1, PC loads the branch target held by the PC unit.
REQ-014 SHALL have ports lu_stall_cnt, flush_cnt, freeze_cnt, output, CNT_W each, performance counters.

Function
REQ-015 SHALL define mem_busy = IM_stall | DM_stall; all outputs except counters are combinational from inputs and state, with zero latency.
REQ-016 SHALL detect load-use as: EX_MemRead, EX_rd_addr != 0, and EX_rd_addr equal to ID_rs1_addr or ID_rs2_addr.
REQ-017 SHALL implement FSM states RUN, FREEZE, FREEZE_REDIR.
REQ-018 In RUN with mem_busy=0: all enables are 1, flushes are 0, and PC_redirect is 0, unless REQ-019 or REQ-020 applies.
REQ-019 Taken branch (pulse in RUN, no mem_busy): PC_redirect=1, IF_ID_flush=1, ID_EX_flush=1, all enables 1; load-use is ignored that cycle.
REQ-020 Load-use without a branch: PC_write=0, IF_ID_write=0, ID_EX_flush=1; downstream enables stay 1; exactly one bubble per dependent load.
REQ-021 mem_busy=1 in any state: every enable is 0, flushes are 0, PC_redirect is 0 (full freeze).
REQ-022 Transitions: RUN->FREEZE on mem_busy with no branch pulse; RUN->FREEZE_REDIR on mem_busy with a branch pulse; FREEZE->FREEZE_REDIR on a pulse while mem_busy; FREEZE/FREEZE_REDIR->RUN when mem_busy=0.
REQ-023 First cycle with mem_busy=0 in FREEZE_REDIR: apply REQ-019 behaviour from the stored redirect, regardless of the live pulse.
REQ-024 First cycle with mem_busy=0 in FREEZE: behave as RUN that cycle, including REQ-019 and REQ-020.
REQ-025 Priority, highest first: freeze, then branch flush (live or stored), then load-use stall.
REQ-026 lu_stall_cnt SHALL increment once per cycle in which REQ-020 is applied.
REQ-027 flush_cnt SHALL increment once per cycle in which PC_redirect=1.
REQ-028 freeze_cnt SHALL increment once per cycle with mem_busy=1.
REQ-029 All counters SHALL wrap modulo 2^CNT_W.

Reset
REQ-030 On rst=0, the FSM SHALL asynchronously enter RUN and all counters SHALL clear to 0.
REQ-031 During reset, outputs SHALL be: enables 1, flushes 0, PC_redirect 0.
REQ-032 A stored redirect SHALL be discarded by reset mid-freeze.
REQ-033 The first edge after reset deassertion SHALL behave as RUN.

Structure
REQ-034 The state enum SHALL live in the shared pipeline package, alongside the 5-bit register-address width and the NOP encoding 32'h00000013.
REQ-035 One sub-module, perf_counter (saturation disabled, wrap, CNT_W), SHALL be instantiated three times; no other hierarchy.

Verification
REQ-036 EX load rd=5, ID rs2=5, no stalls -> one cycle of PC_write=0, IF_ID_write=0, ID_EX_flush=1; lu_stall_cnt=1.
REQ-037 EX load rd=0, ID rs1=0 -> no stall; all enables 1.
REQ-038 DM_stall high for 3 cycles with a branch pulse in cycle 2 -> all enables 0 for 3 cycles, then 1 cycle of PC_redirect=1 with both flushes 1; freeze_cnt=3, flush_cnt=1.
REQ-039 Branch pulse together with a load-use match -> flushes 1, PC_write=1, lu_stall_cnt unchanged.
REQ-040 rst asserted during FREEZE_REDIR -> after release, no PC_redirect is issued and counters read 0.
REQ-041 With CNT_W=4, 17 freeze cycles -> freeze_cnt=1.
